demux_1_4_stream: RTL and testbench
===================================

DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the data word width in bits.
REQ-002 Parameter MODE, default "SEL", SHALL select routing: "SEL" routes by in_sel, "RR" routes round-robin.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark in_data/in_sel as valid.
REQ-006 in_data  input  WIDTH  SHALL carry the word to route.
REQ-007 in_sel  input  2  SHALL carry the destination channel; it is ignored in "RR".
REQ-008 in_ready  output  1  SHALL be high when a valid word will be accepted this cycle.
REQ-009 out_valid  output  4  SHALL flag, per channel, a word held in that channel register.
REQ-010 out_data0..out_data3  output  WIDTH each  SHALL carry each channel register's word.
REQ-011 out_ready  input  4  SHALL indicate, per channel, that the consumer takes the word.
REQ-012 rr_ptr  output  2  SHALL expose the current round-robin destination (always 0 in "SEL").

Function
REQ-013 Transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer where out_valid[i] && out_ready[i].
REQ-014 Destination d SHALL be in_sel in "SEL" and rr_ptr in "RR".
REQ-015 in_ready SHALL equal (!out_valid[d] || out_ready[d]), combinational, with no combinational path from in_valid.
REQ-016 Accepted word SHALL appear on out_data_d with out_valid[d]=1 exactly one cycle after acceptance (latency 1).
REQ-017 Each channel SHALL hold one word; out_valid[i]/out_data_i SHALL stay stable until out_ready[i] is high.
REQ-018 Full channel with out_ready high and a new accept to it in the same cycle SHALL reload the register; out_valid stays 1 (1 word/cycle throughput).
REQ-019 Full channel with out_ready high and no new accept SHALL clear out_valid[i] next cycle; out_data_i holds its last value.
REQ-020 Channels SHALL operate independently; a stalled channel SHALL NOT block accepts to other channels in "SEL".
REQ-021 In "RR", rr_ptr SHALL advance by 1 per accepted word, wrapping 3 -> 0; it SHALL NOT advance without acceptance.
REQ-022 In "RR", a full, stalled rr_ptr channel SHALL hold in_ready low (strict order, no skipping).
REQ-023 in_sel changing without in_valid SHALL cause no state change.

Reset
REQ-024 While rst_n is low: out_valid=4'b0000, all out_data=0, rr_ptr=0, in_ready=0.
REQ-025 Reset asserted mid-operation SHALL discard all held words immediately (asynchronously).
REQ-026 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 Package demux_pkg SHALL hold the channel count (4), the select width (2) and the MODE string constants "SEL"/"RR".
REQ-028 One sub-module, demux_chan_reg (one-entry valid/data register with load/unload), SHALL be instantiated once per channel.
REQ-029 The block SHALL contain no latches; all outputs except in_ready SHALL be registered.

Verification
REQ-030 SEL, out_ready=4'b1111, in_data=2'b11 with in_sel 0,1,2,3 on consecutive cycles -> out_valid 0001,0010,0100,1000 one cycle later each; data 11.
REQ-031 SEL, out_ready[1]=0, two words 2'b10 then 2'b01 to channel 1 -> first held with out_valid[1]=1, in_ready=0 for the second until out_ready[1]=1, then 01 follows next cycle.
REQ-032 SEL, channel 2 stalled; word 2'b01 to channel 0 -> accepted, out_valid[0]=1 next cycle (no blocking).
REQ-033 RR, out_ready all 1, six words 00,01,10,11,01,10 -> channels 0,1,2,3,0,1; rr_ptr sequence 0,1,2,3,0,1,2.
REQ-034 RR, out_ready[2]=0 with channel 2 full and rr_ptr=2 -> in_ready=0 and rr_ptr held at 2 until release.
REQ-035 Any mode, rst_n pulsed low with two channels full -> out_valid=0000, rr_ptr=0 immediately, no outputs delivered after reset.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer: channel count,
// select width and the routing-mode encodings.
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   // Mode strings packed into 24 bits; "RR" is zero-extended on the left
   localparam logic [23:0] MODE_SEL = "SEL";
   localparam logic [23:0] MODE_RR  = "RR";

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register for a single demux channel. A load always wins
// over an unload, so a full slot that is drained and refilled in the same cycle stays valid.
module demux_chan_reg
   import demux_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             unload,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             vld_p1;
   logic [WIDTH-1:0] data_p1;

   // Stage p1: the held word; data keeps its last value after an unload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         data_p1 <= load_data;
      end else if (unload) begin
         vld_p1  <= 1'b0;
      end
   end

   assign valid = vld_p1;
   assign data  = data_p1;

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with one register per channel.
// Routing follows in_sel ("SEL") or a strict round-robin pointer ("RR").
module demux_1_4_stream
   import demux_pkg::*;
#(
   parameter int          WIDTH = 2,
   parameter logic [23:0] MODE  = MODE_SEL
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [SEL_W-1:0]  in_sel,
   output logic              in_ready,
   output logic [NUM_CH-1:0] out_valid,
   output logic [WIDTH-1:0]  out_data0,
   output logic [WIDTH-1:0]  out_data1,
   output logic [WIDTH-1:0]  out_data2,
   output logic [WIDTH-1:0]  out_data3,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [SEL_W-1:0]  rr_ptr
);

   localparam logic RR_MODE = (MODE == MODE_RR);

   logic [SEL_W-1:0]  dest;
   logic              accept;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0] unload;
   logic [WIDTH-1:0]  chan_data [NUM_CH];

   // Readiness depends only on the destination slot, never on in_valid
   assign dest     = RR_MODE ? rr_ptr : in_sel;
   assign in_ready = rst_n & (~out_valid[dest] | out_ready[dest]);
   assign accept   = in_valid & in_ready;

   always_comb begin
      load   = '0;
      unload = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         load[i]   = accept && (dest == SEL_W'(i));
         unload[i] = out_valid[i] & out_ready[i];
      end
   end

   // Pointer only moves on an accepted word, so a stalled channel holds the order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (RR_MODE && accept) begin
         rr_ptr <= rr_ptr + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      demux_chan_reg #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[i]),
         .load_data (in_data),
         .unload    (unload[i]),
         .valid     (out_valid[i]),
         .data      (chan_data[i])
      );
   end

   assign out_data0 = chan_data[0];
   assign out_data1 = chan_data[1];
   assign out_data2 = chan_data[2];
   assign out_data3 = chan_data[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: one SEL-mode and one RR-mode instance driven by
// directed vectors, checked every cycle against a slot-level model plus literals.
module tb_demux_1_4_stream;
   import demux_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;

   // Index 0 is the SEL instance, index 1 the RR instance
   logic       in_valid  [2];
   logic [1:0] in_data   [2];
   logic [1:0] in_sel    [2];
   logic [3:0] out_ready [2];
   logic       in_ready  [2];
   logic [3:0] out_valid [2];
   logic [1:0] out_data  [2][4];
   logic [1:0] rr_ptr    [2];

   // Model: which slots hold a word, what word, and the next RR destination
   logic [3:0] m_valid [2];
   logic [1:0] m_data  [2][4];
   int         m_ptr   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demux_1_4_stream #(.WIDTH(2), .MODE(MODE_SEL)) u_sel (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_sel(in_sel[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
      .out_data0(out_data[0][0]), .out_data1(out_data[0][1]),
      .out_data2(out_data[0][2]), .out_data3(out_data[0][3]),
      .out_ready(out_ready[0]), .rr_ptr(rr_ptr[0])
   );

   demux_1_4_stream #(.WIDTH(2), .MODE(MODE_RR)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_sel(in_sel[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
      .out_data0(out_data[1][0]), .out_data1(out_data[1][1]),
      .out_data2(out_data[1][2]), .out_data3(out_data[1][3]),
      .out_ready(out_ready[1]), .rr_ptr(rr_ptr[1])
   );

   function automatic int dest_of(int u);
      return (u == 1) ? m_ptr[u] : int'(in_sel[u]);
   endfunction

   function automatic logic exp_ready(int u);
      int d;
      d = dest_of(u);
      return rst_n && (!m_valid[u][d] || out_ready[u][d]);
   endfunction

   task automatic chk(string name, int u, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual %0h required %0h at %0t", name, u, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int u = 0; u < 2; u++) begin
         m_valid[u] = 4'b0000;
         m_ptr[u]   = 0;
         for (int c = 0; c < 4; c++) m_data[u][c] = 2'b00;
      end
   endtask

   // A consumer drains its slot; an accepted word then lands in its destination slot
   task automatic model_edge();
      for (int u = 0; u < 2; u++) begin
         int   d;
         logic acc;
         d   = dest_of(u);
         acc = in_valid[u] && exp_ready(u);
         for (int c = 0; c < 4; c++)
            if (m_valid[u][c] && out_ready[u][c]) m_valid[u][c] = 1'b0;
         if (acc) begin
            m_valid[u][d] = 1'b1;
            m_data[u][d]  = in_data[u];
            if (u == 1) m_ptr[u] = (m_ptr[u] + 1) % 4;
         end
      end
   endtask

   task automatic compare_all();
      for (int u = 0; u < 2; u++) begin
         chk("in_ready", u, 8'(in_ready[u]), 8'(exp_ready(u)));
         chk("out_valid", u, 8'(out_valid[u]), 8'(m_valid[u]));
         chk("rr_ptr", u, 8'(rr_ptr[u]), 8'(m_ptr[u]));
         for (int c = 0; c < 4; c++)
            chk("out_data", u, 8'(out_data[u][c]), 8'(m_data[u][c]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] rr_words [6];

   initial begin
      rr_words = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
      for (int u = 0; u < 2; u++) begin
         in_valid[u]  = 1'b0;
         in_data[u]   = 2'b00;
         in_sel[u]    = 2'b00;
         out_ready[u] = 4'b0000;
      end
      model_clear();

      fork
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else        model_edge();
         end
         forever begin
            @(negedge clk);
            compare_all();
         end
      join_none

      // Reset holds everything idle even with a valid word offered
      in_valid[0] = 1'b1;
      in_sel[0]   = 2'd2;
      repeat (3) tick();
      chk("rst_valid", 0, 8'(out_valid[0]), 8'h00);
      chk("rst_ready", 0, 8'(in_ready[0]), 8'h00);
      chk("rst_ptr", 1, 8'(rr_ptr[1]), 8'h00);
      rst_n = 1'b1;

      // SEL sweep over all channels, first accept on the first edge after reset
      out_ready[0] = 4'b1111;
      in_data[0]   = 2'b11;
      for (int s = 0; s < 4; s++) begin
         in_sel[0] = 2'(s);
         tick();
         chk("sel_valid", 0, 8'(out_valid[0]), 8'(1 << s));
         chk("sel_data", 0, 8'(out_data[0][s]), 8'h03);
      end
      in_valid[0] = 1'b0;
      tick();
      chk("sel_drain", 0, 8'(out_valid[0]), 8'h00);

      // Stalled channel 1 holds its word and backpressures the second
      out_ready[0] = 4'b1101;
      in_valid[0]  = 1'b1;
      in_sel[0]    = 2'd1;
      in_data[0]   = 2'b10;
      tick();
      chk("hold_valid", 0, 8'(out_valid[0]), 8'h02);
      chk("hold_data", 0, 8'(out_data[0][1]), 8'h02);
      in_data[0] = 2'b01;
      #1;
      chk("hold_ready", 0, 8'(in_ready[0]), 8'h00);
      tick();
      chk("hold_data2", 0, 8'(out_data[0][1]), 8'h02);
      out_ready[0] = 4'b1111;
      #1;
      chk("release_ready", 0, 8'(in_ready[0]), 8'h01);
      tick();
      chk("reload_valid", 0, 8'(out_valid[0]), 8'h02);
      chk("reload_data", 0, 8'(out_data[0][1]), 8'h01);
      in_valid[0] = 1'b0;
      tick();
      chk("clear_valid", 0, 8'(out_valid[0]), 8'h00);
      chk("keep_data", 0, 8'(out_data[0][1]), 8'h01);

      // Channel 2 stalled full must not block channel 0
      out_ready[0] = 4'b1011;
      in_valid[0]  = 1'b1;
      in_sel[0]    = 2'd2;
      in_data[0]   = 2'b11;
      tick();
      in_sel[0]  = 2'd0;
      in_data[0] = 2'b01;
      #1;
      chk("noblock_ready", 0, 8'(in_ready[0]), 8'h01);
      tick();
      chk("noblock_valid", 0, 8'(out_valid[0]), 8'h05);
      chk("noblock_data", 0, 8'(out_data[0][0]), 8'h01);
      in_valid[0] = 1'b0;
      in_sel[0]   = 2'd1;
      tick();
      in_sel[0]   = 2'd3;
      tick();
      chk("idle_sel", 0, 8'(out_valid[0]), 8'h04);
      out_ready[0] = 4'b1111;
      tick();

      // RR: six words walk channels 0..3 and wrap; in_sel is ignored
      out_ready[1] = 4'b1111;
      in_sel[1]    = 2'd3;
      in_valid[1]  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("rr_ptr_pre", 1, 8'(rr_ptr[1]), 8'(k % 4));
         in_data[1] = rr_words[k];
         tick();
         chk("rr_valid", 1, 8'(out_valid[1]), 8'(1 << (k % 4)));
         chk("rr_data", 1, 8'(out_data[1][k % 4]), 8'(rr_words[k]));
      end
      in_valid[1] = 1'b0;
      tick();
      chk("rr_noadv", 1, 8'(rr_ptr[1]), 8'h02);

      // RR strict order: channel 2 full and stalled stops the pointer at 2
      out_ready[1] = 4'b1011;
      in_valid[1]  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data[1] = 2'(k + 1);
         tick();
      end
      chk("rr_fill", 1, 8'(out_valid[1]), 8'h06);
      chk("rr_at2", 1, 8'(rr_ptr[1]), 8'h02);
      in_data[1] = 2'b11;
      #1;
      chk("rr_stall_ready", 1, 8'(in_ready[1]), 8'h00);
      repeat (2) tick();
      chk("rr_stall_ptr", 1, 8'(rr_ptr[1]), 8'h02);
      chk("rr_stall_data", 1, 8'(out_data[1][2]), 8'h01);
      out_ready[1] = 4'b1111;
      #1;
      chk("rr_release", 1, 8'(in_ready[1]), 8'h01);
      tick();
      chk("rr_reload", 1, 8'(out_data[1][2]), 8'h03);
      chk("rr_ptr3", 1, 8'(rr_ptr[1]), 8'h03);
      in_valid[1] = 1'b0;
      tick();

      // Two full channels in each instance, then an asynchronous reset pulse
      out_ready[0] = 4'b0000;
      out_ready[1] = 4'b0000;
      in_valid[0]  = 1'b1;
      in_valid[1]  = 1'b1;
      in_sel[0]    = 2'd0;
      in_data[0]   = 2'b01;
      in_data[1]   = 2'b01;
      tick();
      in_sel[0]  = 2'd3;
      in_data[0] = 2'b10;
      in_data[1] = 2'b10;
      tick();
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
      chk("full_sel", 0, 8'(out_valid[0]), 8'h09);
      chk("full_rr", 1, 8'(out_valid[1]), 8'h09);
      chk("full_ptr", 1, 8'(rr_ptr[1]), 8'h01);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 0, 8'(out_valid[0]), 8'h00);
      chk("arst_valid", 1, 8'(out_valid[1]), 8'h00);
      chk("arst_ptr", 1, 8'(rr_ptr[1]), 8'h00);
      chk("arst_data", 0, 8'(out_data[0][3]), 8'h00);
      out_ready[0] = 4'b1111;
      out_ready[1] = 4'b1111;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("post_valid", 0, 8'(out_valid[0]), 8'h00);
      chk("post_valid", 1, 8'(out_valid[1]), 8'h00);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
